// File: rtl/ring_vc_router.sv
// Bidirectional ring router: CW/CCW/PE input FIFOs, hop-count routing, per-output
// two-way round-robin and polarity-gated virtual-channel launch onto the ring.
module ring_vc_router #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              polarity,
  input  logic              cwsi,
  output logic              cwri,
  input  logic [DATA_W-1:0] cwdi,
  output logic              cwso,
  input  logic              cwro,
  output logic [DATA_W-1:0] cwdo,
  input  logic              ccwsi,
  output logic              ccwri,
  input  logic [DATA_W-1:0] ccwdi,
  output logic              ccwso,
  input  logic              ccwro,
  output logic [DATA_W-1:0] ccwdo,
  input  logic              pesi,
  output logic              peri,
  input  logic [DATA_W-1:0] pedi,
  output logic              peso,
  input  logic              pero,
  output logic [DATA_W-1:0] pedo
);

  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned VcBit   = DATA_W - 1;
  localparam int unsigned DirBit  = DATA_W - 2;
  localparam int unsigned HopLsb  = DATA_W - 16;
  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  // Index 0/1/2 names both the input FIFO and the output register of that channel.
  localparam int Cw  = 0;
  localparam int Ccw = 1;
  localparam int Pe  = 2;

  typedef logic [DATA_W-1:0] word_t;

  logic          polarity_q;
  word_t         mem_q  [3][DEPTH];
  logic [AW-1:0] wptr_q [3];
  logic [AW-1:0] rptr_q [3];
  logic [AW:0]   cnt_q  [3];
  word_t         in_d   [3];
  word_t         head   [3];
  logic [2:0]    in_s, push, pop, rdy, nonempty;

  logic [2:0]    ro, can_load, req_a, req_b, gnt_a, gnt_b, rr_q, vld_q;
  word_t         cand_a [3];
  word_t         cand_b [3];
  word_t         dat_q  [3];
  word_t         fwd    [2];
  logic [7:0]    hop    [2];
  logic          pe_ok;

  assign in_s      = {pesi, ccwsi, cwsi};
  assign in_d[Cw]  = cwdi;
  assign in_d[Ccw] = ccwdi;
  assign in_d[Pe]  = pedi;
  assign ro        = {pero, ccwro, cwro};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rdy[i]      = cnt_q[i] < FullCnt;
      nonempty[i] = cnt_q[i] != '0;
      head[i]     = mem_q[i][rptr_q[i]];
      push[i]     = in_s[i] && rdy[i];
    end
  end

  // Ring heads eject at hop 0, otherwise continue in the same direction one hop closer.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      hop[i]                = head[i][HopLsb +: 8];
      fwd[i]                = head[i];
      fwd[i][HopLsb +: 8]   = hop[i] - 8'd1;
    end
    pe_ok = nonempty[Pe] && (head[Pe][VcBit] == polarity_q);

    req_a[Cw]  = nonempty[Cw] && (hop[Cw] != 8'd0) && (head[Cw][VcBit] == polarity_q);
    req_b[Cw]  = pe_ok && !head[Pe][DirBit];
    req_a[Ccw] = nonempty[Ccw] && (hop[Ccw] != 8'd0) && (head[Ccw][VcBit] == polarity_q);
    req_b[Ccw] = pe_ok && head[Pe][DirBit];
    req_a[Pe]  = nonempty[Cw] && (hop[Cw] == 8'd0);
    req_b[Pe]  = nonempty[Ccw] && (hop[Ccw] == 8'd0);

    cand_a[Cw]  = fwd[Cw];
    cand_b[Cw]  = head[Pe];
    cand_a[Ccw] = fwd[Ccw];
    cand_b[Ccw] = head[Pe];
    cand_a[Pe]  = head[Cw];
    cand_b[Pe]  = head[Ccw];
  end

  // rr_q = 0 favours requester a (the ring-side input); a lone requester always wins.
  always_comb begin
    for (int o = 0; o < 3; o++) begin
      can_load[o] = !vld_q[o] || ro[o];
      gnt_a[o]    = can_load[o] && req_a[o] && (!req_b[o] || !rr_q[o]);
      gnt_b[o]    = can_load[o] && req_b[o] && (!req_a[o] || rr_q[o]);
    end
  end

  // Routing sends each head to exactly one output, so at most one pop source fires.
  always_comb begin
    pop      = '0;
    pop[Cw]  = gnt_a[Cw] | gnt_a[Pe];
    pop[Ccw] = gnt_a[Ccw] | gnt_b[Pe];
    pop[Pe]  = gnt_b[Cw] | gnt_b[Ccw];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      polarity_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      polarity_q <= ~polarity_q;
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wptr_q[i] <= wptr_q[i] + AW'(1);
        if (pop[i])  rptr_q[i] <= rptr_q[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt_q[i] <= cnt_q[i] + (AW+1)'(1);
          2'b01:   cnt_q[i] <= cnt_q[i] - (AW+1)'(1);
          default: cnt_q[i] <= cnt_q[i];
        endcase
      end
    end
  end

  // Storage needs no reset: the cleared pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem_q[i][wptr_q[i]] <= in_d[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      rr_q  <= '0;
      for (int o = 0; o < 3; o++) dat_q[o] <= '0;
    end else begin
      for (int o = 0; o < 3; o++) begin
        if (gnt_a[o] || gnt_b[o]) begin
          vld_q[o] <= 1'b1;
          dat_q[o] <= gnt_a[o] ? cand_a[o] : cand_b[o];
          rr_q[o]  <= gnt_a[o];
        end else if (ro[o]) begin
          vld_q[o] <= 1'b0;
        end
      end
    end
  end

  assign polarity = polarity_q;
  assign cwri     = rdy[Cw];
  assign ccwri    = rdy[Ccw];
  assign peri     = rdy[Pe];
  assign cwso     = vld_q[Cw];
  assign ccwso    = vld_q[Ccw];
  assign peso     = vld_q[Pe];
  assign cwdo     = dat_q[Cw];
  assign ccwdo    = dat_q[Ccw];
  assign pedo     = dat_q[Pe];

endmodule
